// File: rtl/dro_readout_checker.sv
// Runtime checker for a DRO cell's toggle-encoded set/reset/out lines.
// Models the cell state, flags protocol/timing violations and counts
// good readouts and violations with saturating counters.
//
// state    | meaning
// EMPTY    | no flux quantum stored
// STORED   | flux quantum stored, waiting for a reset
// WAIT_OUT | reset seen, waiting for the out pulse
module dro_readout_checker #(
  parameter int SETUP_CYC   = 3,
  parameter int OUT_LAT_MAX = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_i,
  input  logic             reset_i,
  input  logic             out_i,
  output logic             stored_o,
  output logic             busy_o,
  output logic             err_setup_o,
  output logic             err_double_o,
  output logic             err_missing_o,
  output logic             err_spurious_o,
  output logic [CNT_W-1:0] read_cnt_o,
  output logic [CNT_W-1:0] viol_cnt_o
);

  localparam int SEP_W = (SETUP_CYC < 1) ? 1 : $clog2(SETUP_CYC + 1);
  localparam int LAT_W = (OUT_LAT_MAX < 1) ? 1 : $clog2(OUT_LAT_MAX + 1);
  localparam logic [SEP_W-1:0] SEP_MAX = SEP_W'(SETUP_CYC);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(OUT_LAT_MAX);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_STORED   = 2'd1,
    ST_WAIT_OUT = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [2:0]       sync1, sync2, hist;
  logic             ev_set, ev_reset, ev_out;
  logic             strict, strict_d;
  logic             pend, pend_d;
  logic [SEP_W-1:0] sep_cnt, sep_d;
  logic [LAT_W-1:0] lat_cnt, lat_d;
  logic             read_inc;
  logic             wait_exit;
  logic [CNT_W:0]   viol_sum;
  logic [CNT_W:0]   read_sum;

  // Bit order is {out, reset, set}; all lines share one path so their
  // relative spacing survives synchronization.
  assign ev_set   = sync2[0] ^ hist[0];
  assign ev_reset = sync2[1] ^ hist[1];
  assign ev_out   = sync2[2] ^ hist[2];

  assign stored_o = (state == ST_STORED);
  assign busy_o   = (state == ST_WAIT_OUT);

  // Two-flop synchronizer plus history flop for edge (event) detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= {out_i, reset_i, set_i};
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Cell model: next state, timers and violation pulses.
  always_comb begin
    state_d        = state;
    strict_d       = strict;
    pend_d         = pend;
    sep_d          = (sep_cnt < SEP_MAX) ? sep_cnt + 1'b1 : sep_cnt;
    lat_d          = lat_cnt;
    read_inc       = 1'b0;
    wait_exit      = 1'b0;
    err_setup_o    = 1'b0;
    err_double_o   = 1'b0;
    err_missing_o  = 1'b0;
    err_spurious_o = 1'b0;
    case (state)
      ST_EMPTY: begin
        err_spurious_o = ev_out;
        if (ev_set && ev_reset) begin
          err_setup_o = 1'b1;
          state_d     = ST_WAIT_OUT;
          strict_d    = 1'b0;
          lat_d       = '0;
          pend_d      = 1'b0;
        end else if (ev_set) begin
          state_d = ST_STORED;
          sep_d   = '0;
        end
      end
      ST_STORED: begin
        err_spurious_o = ev_out;
        if (ev_reset) begin
          // Reset is handled first; a coincident set re-arms via pending.
          strict_d    = (sep_cnt >= SEP_MAX);
          err_setup_o = (sep_cnt < SEP_MAX);
          state_d     = ST_WAIT_OUT;
          lat_d       = '0;
          pend_d      = ev_set;
        end else if (ev_set) begin
          err_double_o = 1'b1;
          sep_d        = '0;
        end
      end
      ST_WAIT_OUT: begin
        if (ev_set) begin
          pend_d = 1'b1;
        end
        if (ev_out) begin
          wait_exit = 1'b1;
          read_inc  = strict;
        end else if (lat_cnt == LAT_MAX) begin
          wait_exit     = 1'b1;
          err_missing_o = strict;
        end else begin
          lat_d = lat_cnt + 1'b1;
        end
        if (wait_exit) begin
          state_d = pend_d ? ST_STORED : ST_EMPTY;
          sep_d   = '0;
          pend_d  = 1'b0;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Saturating sums; a carry out of the top bit means overflow.
  always_comb begin
    viol_sum = {1'b0, viol_cnt_o} + (CNT_W+1)'(err_setup_o) + (CNT_W+1)'(err_double_o)
             + (CNT_W+1)'(err_missing_o) + (CNT_W+1)'(err_spurious_o);
    read_sum = {1'b0, read_cnt_o} + (CNT_W+1)'(read_inc);
  end

  // State, timers and counters register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      strict     <= 1'b0;
      pend       <= 1'b0;
      sep_cnt    <= '0;
      lat_cnt    <= '0;
      read_cnt_o <= '0;
      viol_cnt_o <= '0;
    end else begin
      state      <= state_d;
      strict     <= strict_d;
      pend       <= pend_d;
      sep_cnt    <= sep_d;
      lat_cnt    <= lat_d;
      read_cnt_o <= read_sum[CNT_W] ? '1 : read_sum[CNT_W-1:0];
      viol_cnt_o <= viol_sum[CNT_W] ? '1 : viol_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_dro_readout_checker.sv
// Bench for dro_readout_checker: scenario tasks with a pulse scoreboard.
module tb_dro_readout_checker;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             set_i = 1'b0;
  logic             reset_i = 1'b0;
  logic             out_i = 1'b0;
  logic             stored_o, busy_o;
  logic             err_setup_o, err_double_o, err_missing_o, err_spurious_o;
  logic [CNT_W-1:0] read_cnt_o, viol_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];
  int exp_read = 0;
  int exp_viol = 0;
  int cyc = 0;
  int busy_rise = -1000;
  int missing_cyc = -100;
  int busy_cycles = 0;
  logic busy_prev = 1'b0;

  dro_readout_checker #(.SETUP_CYC(3), .OUT_LAT_MAX(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .set_i(set_i), .reset_i(reset_i), .out_i(out_i),
    .stored_o(stored_o), .busy_o(busy_o),
    .err_setup_o(err_setup_o), .err_double_o(err_double_o),
    .err_missing_o(err_missing_o), .err_spurious_o(err_spurious_o),
    .read_cnt_o(read_cnt_o), .viol_cnt_o(viol_cnt_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed err pulse pops the oldest expectation.
  // Codes: 1 setup, 2 double, 3 missing, 4 spurious.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      logic [3:0] p;
      cyc++;
      if (busy_o && !busy_prev) busy_rise = cyc;
      busy_prev = busy_o;
      if (busy_o) busy_cycles++;
      if (err_missing_o) missing_cyc = cyc;
      p = {err_spurious_o, err_missing_o, err_double_o, err_setup_o};
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_err got code %0d want none", k + 1);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (e != k + 1) begin
              n_fail++;
              $display("FAIL err_order got code %0d want %0d", k + 1, e);
            end
          end
        end
      end
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // which: 0 set, 1 reset, 2 out
  task automatic tog(input int which);
    @(posedge clk);
    #1;
    case (which)
      0: set_i = ~set_i;
      1: reset_i = ~reset_i;
      default: out_i = ~out_i;
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    n_assert++;
    if ({stored_o, busy_o, err_setup_o, err_double_o, err_missing_o, err_spurious_o,
         read_cnt_o, viol_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %b/%b/%0d/%0d want all zero", stored_o, busy_o,
               read_cnt_o, viol_cnt_o);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_read();
    busy_cycles = 0;
    tog(0);
    idle(5);
    @(negedge clk);
    n_assert++;
    if (stored_o !== 1'b1) begin
      n_fail++;
      $display("FAIL good_stored got %b want 1", stored_o);
    end
    idle(3);
    tog(1);
    idle(1);
    tog(2);
    idle(8);
    exp_read++;
    @(negedge clk);
    n_assert++;
    if (busy_cycles != 2) begin
      n_fail++;
      $display("FAIL good_busy_cycles got %0d want 2", busy_cycles);
    end
    n_assert++;
    if (read_cnt_o !== CNT_W'(exp_read) || viol_cnt_o !== CNT_W'(exp_viol)) begin
      n_fail++;
      $display("FAIL good_counts got %0d/%0d want %0d/%0d", read_cnt_o, viol_cnt_o, exp_read, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL good_pending_exp got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_setup();
    exp_q.push_back(1);
    exp_viol++;
    tog(0);
    tog(1);
    idle(1);
    tog(2);
    idle(8);
    @(negedge clk);
    n_assert++;
    if (read_cnt_o !== CNT_W'(exp_read) || viol_cnt_o !== CNT_W'(exp_viol)) begin
      n_fail++;
      $display("FAIL setup_counts got %0d/%0d want %0d/%0d", read_cnt_o, viol_cnt_o, exp_read, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL setup_missed_pulse got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_missing();
    exp_q.push_back(3);
    exp_viol++;
    missing_cyc = -100;
    tog(0);
    idle(9);
    tog(1);
    idle(14);
    @(negedge clk);
    n_assert++;
    if (missing_cyc - busy_rise != 4) begin
      n_fail++;
      $display("FAIL missing_latency got %0d want 4", missing_cyc - busy_rise);
    end
    n_assert++;
    if (stored_o !== 1'b0 || busy_o !== 1'b0 || viol_cnt_o !== CNT_W'(exp_viol)) begin
      n_fail++;
      $display("FAIL missing_state got %b/%b/%0d want 0/0/%0d", stored_o, busy_o, viol_cnt_o, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_missed_pulse got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_double();
    exp_q.push_back(2);
    exp_viol++;
    exp_read++;
    tog(0);
    idle(4);
    tog(0);
    idle(9);
    tog(1);
    idle(1);
    tog(2);
    idle(8);
    @(negedge clk);
    n_assert++;
    if (read_cnt_o !== CNT_W'(exp_read) || viol_cnt_o !== CNT_W'(exp_viol)) begin
      n_fail++;
      $display("FAIL double_counts got %0d/%0d want %0d/%0d", read_cnt_o, viol_cnt_o, exp_read, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL double_missed_pulse got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_spurious();
    exp_q.push_back(4);
    exp_viol++;
    tog(2);
    idle(8);
    @(negedge clk);
    n_assert++;
    if (viol_cnt_o !== CNT_W'(exp_viol) || stored_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL spurious_state got %0d/%b/%b want %0d/0/0", viol_cnt_o, stored_o, busy_o, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL spurious_missed_pulse got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_pending();
    tog(0);
    idle(9);
    tog(1);
    tog(0);
    tog(2);
    idle(6);
    exp_read++;
    @(negedge clk);
    n_assert++;
    if (stored_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_stored got %b/%b want 1/0", stored_o, busy_o);
    end
    idle(9);
    tog(1);
    idle(1);
    tog(2);
    idle(8);
    exp_read++;
    @(negedge clk);
    n_assert++;
    if (read_cnt_o !== CNT_W'(exp_read) || viol_cnt_o !== CNT_W'(exp_viol)) begin
      n_fail++;
      $display("FAIL pending_counts got %0d/%0d want %0d/%0d", read_cnt_o, viol_cnt_o, exp_read, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_missed_pulse got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_saturate_abort();
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(4);
      tog(2);
    end
    exp_viol = (exp_viol + 300 > 255) ? 255 : exp_viol + 300;
    idle(8);
    @(negedge clk);
    n_assert++;
    if (viol_cnt_o !== CNT_W'(exp_viol)) begin
      n_fail++;
      $display("FAIL saturate_viol got %0d want %0d", viol_cnt_o, exp_viol);
    end
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL saturate_missed_pulse got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    tog(0);
    idle(9);
    tog(1);
    idle(4);
    @(negedge clk);
    n_assert++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before got %b want 1", busy_o);
    end
    #1;
    rst_n = 1'b0;
    set_i = 1'b0;
    reset_i = 1'b0;
    out_i = 1'b0;
    #1;
    n_assert++;
    if ({stored_o, busy_o, err_setup_o, err_double_o, err_missing_o, err_spurious_o,
         read_cnt_o, viol_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL abort_clear got %b/%b/%0d/%0d want all zero", stored_o, busy_o,
               read_cnt_o, viol_cnt_o);
    end
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    @(negedge clk);
    n_assert++;
    if ({stored_o, busy_o, read_cnt_o, viol_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL abort_after got %b/%b/%0d/%0d want all zero", stored_o, busy_o,
               read_cnt_o, viol_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_good_read();
    test_setup();
    test_missing();
    test_double();
    test_spurious();
    test_pending();
    test_saturate_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
